// File: rtl/md_ctrl.sv
// HI/LO multiply-divide unit. It computes a result when an operation is accepted,
// holds it pending for a fixed number of busy cycles, then commits it to HI/LO.
module md_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_W = $clog2(DIV_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [CNT_W-1:0] cnt;
  logic [31:0]      p_hi;
  logic [31:0]      p_lo;
  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic [63:0]      res;
  logic [CNT_W-1:0] load_cnt;

  function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return 64'(ea * eb);
  endfunction

  function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {32'd0, a};
    eb = {32'd0, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}; the caller handles b == 0.
  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    return {a % b, a / b};
  endfunction

  // Magnitude divide, then fix signs: quotient truncates toward zero and the
  // remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000 rem 0.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;
    ua = a[31] ? (~a + 32'd1) : a;
    ub = b[31] ? (~b + 32'd1) : b;
    uq = ua / ub;
    ur = ua % ub;
    q  = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
    r  = a[31] ? (~ur + 32'd1) : ur;
    return {r, q};
  endfunction

  assign busy   = (cnt != '0);
  assign stall  = md_use_D & (start | busy);
  assign accept = start & ~busy;
  assign is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);

  always_comb begin
    res      = {HI, LO};
    load_cnt = '0;
    case (md_op)
      OP_MULT:  begin res = mul_signed(A, B);   load_cnt = MULT_LD; end
      OP_MULTU: begin res = mul_unsigned(A, B); load_cnt = MULT_LD; end
      OP_DIV: begin
        if (B != 32'd0) res = div_signed(A, B);
        load_cnt = DIV_LD;
      end
      OP_DIVU: begin
        if (B != 32'd0) res = div_unsigned(A, B);
        load_cnt = DIV_LD;
      end
      default: begin res = {HI, LO}; load_cnt = '0; end
    endcase
  end

  // Accepted operations are mutually exclusive with a commit because accept
  // requires busy == 0, so HI/LO see at most one update per edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      p_hi <= '0;
      p_lo <= '0;
      HI   <= '0;
      LO   <= '0;
    end else begin
      if (accept && (is_mul || is_div)) begin
        p_hi <= res[63:32];
        p_lo <= res[31:0];
        cnt  <= load_cnt;
      end else if (busy) begin
        cnt <= cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          HI <= p_hi;
          LO <= p_lo;
        end
      end
      if (accept && (md_op == OP_MTHI)) HI <= A;
      if (accept && (md_op == OP_MTLO)) LO <= A;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: constant vector table, model-driven random ops,
// and hand sequences for start-while-busy and mid-operation reset.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_use_D;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        use_d;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          ecyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[14];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .md_use_D(md_use_D), .busy(busy), .stall(stall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Independent reference: signed product via unsigned product with
  // two's-complement corrections; signed divide done in 64-bit arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ehi, output logic [31:0] elo, output int ecyc);
    logic [63:0]        p;
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    logic signed [63:0] q;
    logic signed [63:0] r;
    ehi = m_hi; elo = m_lo; ecyc = 0;
    case (op)
      3'd0, 3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        if (op == 3'd0) begin
          if (a[31]) p = p - {b, 32'd0};
          if (b[31]) p = p - {a, 32'd0};
        end
        ehi = p[63:32]; elo = p[31:0]; ecyc = 5;
      end
      3'd2: begin
        ecyc = 10;
        if (b != 0) begin
          sa = $signed({{32{a[31]}}, a});
          sbv = $signed({{32{b[31]}}, b});
          q = sa / sbv; r = sa % sbv;
          ehi = r[31:0]; elo = q[31:0];
        end
      end
      3'd3: begin
        ecyc = 10;
        if (b != 0) begin ehi = a % b; elo = a / b; end
      end
      3'd4: ehi = a;
      3'd5: elo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input logic [31:0] ehi, input logic [31:0] elo,
                        input int ecyc, input string name);
    exp_t e;
    int   n;
    bit   done;
    bit   stall_ok;
    sb.push_back('{hi: ehi, lo: elo, cyc: ecyc});
    @(negedge clk);
    start = 1'b1; md_op = op; A = a; B = b; md_use_D = use_d;
    #1;
    stall_ok = (stall === use_d);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        n++;
        if (stall !== use_d) stall_ok = 0;
      end else begin
        done = 1;
        if (stall !== 1'b0) stall_ok = 0;
      end
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s_timeout: busy still high after 40 cycles", name);
    end
    e = sb.pop_front();
    chk({name, "_cycles"}, 32'(n), 32'(e.cyc));
    chk({name, "_HI"}, HI, e.hi);
    chk({name, "_LO"}, LO, e.lo);
    chk({name, "_stall"}, {31'd0, stall_ok}, 32'd1);
    md_use_D = 1'b0;
    m_hi = e.hi; m_lo = e.lo;
  endtask

  initial begin
    int          n;
    bit          flag;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          ecyc;

    tbl[0]  = '{3'd0, 32'hFFFFFFFF, 32'd2,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        1'b0, 32'h00000001, 32'hFFFFFFFE, 5};
    tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[3]  = '{3'd3, 32'd7,        32'd2,        1'b1, 32'd1,        32'd3,        10};
    tbl[4]  = '{3'd4, 32'h11,       32'd0,        1'b0, 32'h11,       32'd3,        0};
    tbl[5]  = '{3'd5, 32'h22,       32'd0,        1'b1, 32'h11,       32'h22,       0};
    tbl[6]  = '{3'd3, 32'd99,       32'd0,        1'b0, 32'h11,       32'h22,       10};
    tbl[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 10};
    tbl[8]  = '{3'd6, 32'h5555,     32'd1,        1'b0, 32'd0,        32'h80000000, 0};
    tbl[9]  = '{3'd7, 32'hAAAA,     32'd3,        1'b0, 32'd0,        32'h80000000, 0};
    tbl[10] = '{3'd5, 32'h1234,     32'd0,        1'b0, 32'd0,        32'h1234,     0};
    tbl[11] = '{3'd2, 32'd7,        32'hFFFFFFFE, 1'b0, 32'd1,        32'hFFFFFFFD, 10};
    tbl[12] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0,        32'd1,        5};
    tbl[13] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'd1,        5};

    reset = 1'b0; start = 1'b0; md_op = 3'd0; A = '0; B = '0; md_use_D = 1'b0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_HI", HI, 32'd0);
    chk("reset_LO", LO, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].use_d, tbl[i].ehi, tbl[i].elo,
             tbl[i].ecyc, $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom();
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      if (i == 3) begin op = 3'd2; a = 32'h80000000; b = 32'hFFFFFFFF; end
      model(op, a, b, ehi, elo, ecyc);
      run_op(op, a, b, 1'($urandom_range(0, 1)), ehi, elo, ecyc, $sformatf("rnd%0d", i));
    end

    // Starts presented while busy must be ignored: result and length unchanged.
    run_op(3'd4, 32'h0BAD0BAD, 32'd0, 1'b0, 32'h0BAD0BAD, m_lo, 0, "pre_mthi");
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; A = 32'd3; B = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; flag = 0;
    for (int k = 0; k < 40 && !flag; k++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        n++;
        if (n == 2) begin start = 1'b1; md_op = 3'd4; A = 32'hDEAD; end
        if (n == 3) begin md_op = 3'd2; A = 32'd100; B = 32'd7; end
        if (n == 4) begin md_op = 3'd5; A = 32'hBEEF; end
        if (n == 5) start = 1'b0;
      end else flag = 1;
    end
    start = 1'b0;
    chk("busy_ignore_cycles", 32'(n), 32'd5);
    chk("busy_ignore_HI", HI, 32'd0);
    chk("busy_ignore_LO", LO, 32'd15);
    m_hi = 32'd0; m_lo = 32'd15;

    // Reset pulsed in the middle of a divide aborts it with nothing committed.
    run_op(3'd4, 32'h77, 32'd0, 1'b0, 32'h77, 32'd15, 0, "pre_rst");
    @(negedge clk);
    start = 1'b1; md_op = 3'd2; A = 32'd100; B = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_HI", HI, 32'd0);
    chk("rst_async_LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    flag = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) flag = 1;
    end
    chk("post_rst_no_commit", {31'd0, flag}, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    run_op(3'd1, 32'h10000, 32'h10000, 1'b1, 32'd1, 32'd0, 5, "post_rst_multu");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5, meaning busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYC, default 10, meaning busy cycles for div/divu.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  E-stage multiply/divide/move instruction issues this cycle.
REQ-006 md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110 and 111 are no-op.
REQ-007 A  input  32  forwarded rs operand, the same value that drives ALU input A.
REQ-008 B  input  32  forwarded rt operand, the same value as the forwarded RD2.
REQ-009 md_use_D  input  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
REQ-010 busy  output  1  an operation is in flight.
REQ-011 stall  output  1  freeze request to the D/E pipeline registers.
REQ-012 HI  output  32  architectural HI register.
REQ-013 LO  output  32  architectural LO register.

Function
REQ-014 SHALL hold an internal down-counter cnt of ceil(log2(DIV_CYC+1)) bits, plus pending result registers pHI and pLO.
REQ-015 SHALL drive busy = (cnt != 0), combinationally from the counter.
REQ-016 SHALL drive stall = md_use_D & (start | busy), combinationally.
REQ-017 SHALL, on an edge with start=1, busy=0 and md_op in {000,001}: compute the 64-bit product of A and B, signed for 000 and unsigned for 001; load {pHI,pLO} with it; load cnt with MULT_CYC.
REQ-018 SHALL, on an edge with start=1, busy=0 and md_op in {010,011}: load pLO with the quotient and pHI with the remainder, then load cnt with DIV_CYC.
REQ-019 SHALL produce, for signed divide, a quotient truncated toward zero and a remainder carrying the sign of the dividend; 0x80000000 / -1 gives quotient 0x80000000 and remainder 0.
REQ-020 SHALL, on divide with B=0, load pHI=HI and pLO=LO so that both are unchanged at completion, and SHALL still be busy for DIV_CYC cycles.
REQ-021 SHALL, on an edge with start=1, busy=0 and md_op=100 (or 101), write A into HI (or LO) at that edge, with no busy cycles.
REQ-022 SHALL ignore start while busy=1; upstream stall guarantees this does not occur, and the bench checks that state is unaffected.
REQ-023 SHALL decrement cnt by 1 on each edge while cnt != 0, unless a new operation loads it.
REQ-024 SHALL, on the edge where cnt goes from 1 to 0, copy pHI to HI and pLO to LO.
REQ-025 SHALL therefore raise busy for exactly N cycles after the start edge, with new HI/LO visible in the first cycle busy=0.
REQ-026 SHALL, with md_op in {110,111} and start=1, change no state.
REQ-027 SHALL keep HI/LO stable except at the edges defined in REQ-021 and REQ-024.

Reset
REQ-028 SHALL, while reset=0 and independent of clk, force cnt=0, HI=0, LO=0, pHI=0, pLO=0; busy and stall then follow as 0 when md_use_D=0.
REQ-029 SHALL abort an in-flight operation when reset is asserted mid-operation, leaving HI/LO=0 and no result committed after release.
REQ-030 SHALL begin normal operation on the first rising edge after reset returns to 1.

Verification
REQ-031 mult with A=0xFFFFFFFF, B=2 -> busy for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFE; with multu instead -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 div with A=-7, B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1); divu with A=7, B=2 -> LO=3, HI=1.
REQ-033 divu with B=0 from HI=0x11, LO=0x22 -> busy for 10 cycles, then HI=0x11 and LO=0x22 unchanged.
REQ-034 mult started with md_use_D=1 held -> stall=1 in the start cycle and for all 5 busy cycles, then stall=0 at the first cycle busy=0; with md_use_D=0 -> stall=0 throughout.
REQ-035 mtlo with A=0x1234 and busy=0 -> LO=0x1234 after one edge and busy stays 0; start with mthi while busy -> HI unchanged.
REQ-036 reset pulsed low at busy cycle 3 of a div -> busy=0 immediately and HI=LO=0, and no later commit occurs.
